// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction-fetch front end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_pc_reg.sv
// ============================================================================
// Module : pc_reg
// Brief  : Architectural PC with reset, load and increment-by-4 (load wins).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : Single-outstanding instruction fetch with redirect/stale-drop.
//          Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect -> TRAP_VEC.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_trap
);

  fetch_state_e state_q, state_d;
  logic         active_q;
  logic [31:0]  pc;
  logic         pc_load;
  logic         pc_inc;
  logic [31:0]  pc_target;
  logic         redir_misaligned;
  logic [31:0]  inst_data_q, inst_data_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_misaligned = redirect_pc[1];
`else
  assign redir_misaligned = 1'b0;
`endif

  assign pc_target = redir_misaligned ? TRAP_VEC : word_align(redirect_pc);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (pc_load),
    .load_val_i (pc_target),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  // active_q holds off the first request until one edge with reset_n high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_REQ;
      active_q    <= 1'b0;
      inst_data_q <= 32'h0;
      inst_pc_q   <= 32'h0;
      pc_plus4_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      active_q    <= 1'b1;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
      pc_plus4_q  <= pc_plus4_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;
    pc_plus4_d  = pc_plus4_q;
    if (active_q) begin
      if (redirect_valid) begin
        // A request already accepted by memory leaves a response to discard.
        pc_load = 1'b1;
        case (state_q)
          S_REQ:   state_d = imem_req_ready ? S_DROP : S_REQ;
          S_HOLD:  state_d = S_REQ;
          default: state_d = imem_rsp_valid ? S_REQ : S_DROP;
        endcase
      end else begin
        case (state_q)
          S_REQ: begin
            if (imem_req_ready) state_d = S_WAIT;
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              inst_data_d = imem_rsp_data;
              inst_pc_d   = pc;
              pc_plus4_d  = pc + 32'd4;
              state_d     = S_HOLD;
            end
          end
          S_HOLD: begin
            if (inst_ready) begin
              pc_inc  = 1'b1;
              state_d = S_REQ;
            end
          end
          default: begin
            if (imem_rsp_valid) state_d = S_REQ;
          end
        endcase
      end
    end
  end

  assign imem_req_valid = active_q && (state_q == S_REQ);
  assign imem_req_addr  = imem_req_valid ? pc : 32'h0;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign pc_plus4       = pc_plus4_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= active_q && redirect_valid && redirect_pc[1];
    end
  end

  assign misalign_trap = trap_q;
`else
  assign misalign_trap = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Directed self-checking bench for fetch_unit with a reference model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_ready = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        misalign_trap;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .pc_plus4       (pc_plus4),
    .misalign_trap  (misalign_trap)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ NOP;
  endfunction

  // Memory responder: one response per accepted request, lat cycles late.
  int          lat = 0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          stale_next = 1'b0;
  bit          hs_now = 1'b0;
  logic [31:0] hs_addr = 32'h0;
  bit          edge_rn = 1'b0;

  always @(posedge clk) begin
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (!edge_rn) begin
      pend = 1'b0;
    end else begin
      if (hs_now) begin
        pend      = 1'b1;
        cnt       = lat;
        pend_addr = hs_addr;
      end
      if (pend) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = stale_next ? 32'hDEAD_BEEF : mem_word(pend_addr);
          stale_next     = 1'b0;
          pend           = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Reference model: architectural PC stream, checked every cycle.
  logic [31:0] model_pc = RESET_PC_DEFAULT;
  bit          prev_rn = 1'b0;
  bit          exp_trap = 1'b0;
  bit          prev_hold_req = 1'b0;
  bit          prev_redir = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] req_log[$];
  logic [31:0] ret_pc[$];
  logic [31:0] ret_p4[$];

  always @(negedge clk) begin
    bit rn;
    bit mis;
    rn     = reset_n;
    hs_now = 1'b0;
    if (!prev_rn) begin
      check("rst_zero_ctrl", {29'h0, imem_req_valid, inst_valid, misalign_trap}, 32'h0);
      check("rst_zero_data", inst_data | inst_pc | pc_plus4 | imem_req_addr, 32'h0);
      exp_trap      = 1'b0;
      prev_hold_req = 1'b0;
      prev_redir    = 1'b0;
    end else begin
      check("misalign_trap", {31'h0, misalign_trap}, {31'h0, exp_trap});
      if (prev_hold_req) begin
        check("req_hold_valid", {31'h0, imem_req_valid}, 32'h1);
        check("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (prev_redir) check("inst_valid_after_redirect", {31'h0, inst_valid}, 32'h0);
      if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);
      if (inst_valid) begin
        check("inst_pc", inst_pc, model_pc);
        check("pc_plus4", pc_plus4, model_pc + 32'd4);
        check("inst_data", inst_data, mem_word(model_pc));
      end
      if (imem_req_valid && imem_req_ready && rn) begin
        hs_now  = 1'b1;
        hs_addr = imem_req_addr;
        req_log.push_back(imem_req_addr);
      end
      exp_trap      = 1'b0;
      prev_redir    = 1'b0;
      prev_hold_req = 1'b0;
      if (rn) begin
        prev_hold_req = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr     = imem_req_addr;
        if (redirect_valid) begin
          mis        = TRAP_EN && redirect_pc[1];
          model_pc   = mis ? TRAP_VEC_DEFAULT : (redirect_pc & 32'hFFFF_FFFC);
          exp_trap   = mis;
          prev_redir = 1'b1;
        end else if (inst_valid && inst_ready) begin
          ret_pc.push_back(inst_pc);
          ret_p4.push_back(pc_plus4);
          model_pc = model_pc + 32'd4;
        end
      end
    end
    if (!rn) model_pc = RESET_PC_DEFAULT;
    edge_rn = rn;
    prev_rn = rn;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    cyc(2);
    req_log.delete();
    ret_pc.delete();
    ret_p4.delete();
    reset_n = 1'b1;
  endtask

  task automatic wait_req(input int n, input int budget, input string name);
    int k = 0;
    while (req_log.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    check({name, "_req_timeout"}, 32'(req_log.size() >= n), 32'h1);
  endtask

  task automatic wait_ret(input int n, input int budget, input string name);
    int k = 0;
    while (ret_pc.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    check({name, "_ret_timeout"}, 32'(ret_pc.size() >= n), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // Reset release, zero-wait memory, decode always ready.
    lat = 0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    do_reset();
    @(negedge clk);
    check("t1_no_req_in_release", {31'h0, imem_req_valid}, 32'h0);
    cyc(1);
    @(negedge clk);
    check("t1_first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("t1_first_req_addr", imem_req_addr, 32'h0);
    wait_ret(3, 30, "t1");
    check("t1_req0", req_log[0], 32'h0);
    check("t1_req1", req_log[1], 32'h4);
    check("t1_req2", req_log[2], 32'h8);
    check("t1_pc0", ret_pc[0], 32'h0);
    check("t1_pc1", ret_pc[1], 32'h4);
    check("t1_pc2", ret_pc[2], 32'h8);
    check("t1_p4_0", ret_p4[0], 32'h4);
    check("t1_p4_1", ret_p4[1], 32'h8);
    check("t1_p4_2", ret_p4[2], 32'hC);

    // Memory stalls the grant for four cycles.
    imem_req_ready = 1'b0;
    do_reset();
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_stall_valid", {31'h0, imem_req_valid}, 32'h1);
      check("t2_stall_addr", imem_req_addr, 32'h0);
      check("t2_stall_no_inst", {31'h0, inst_valid}, 32'h0);
      cyc(1);
    end
    imem_req_ready = 1'b1;
    wait_ret(1, 20, "t2");
    check("t2_pc0", ret_pc[0], 32'h0);

    // Redirect while waiting; the late response is stale and must vanish.
    lat = 2; stale_next = 1'b1;
    do_reset();
    wait_req(1, 10, "t3a");
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc(1);
    redirect_valid = 1'b0; lat = 0;
    wait_ret(1, 30, "t3");
    check("t3_req_after_redirect", req_log[1], 32'h200);
    check("t3_inst_pc", ret_pc[0], 32'h200);
    check("t3_stale_consumed", {31'h0, stale_next}, 32'h0);

    // Redirect beats inst_ready in the hold cycle at pc 0x10.
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      cyc(1);
      if (inst_valid && inst_pc == 32'h10) found = 1'b1;
    end
    check("t4_reached_0x10", {31'h0, found}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
    cyc(1);
    redirect_valid = 1'b0;
    wait_ret(5, 30, "t4");
    check("t4_req_after_redirect", req_log[5], 32'h40);
    check("t4_retired_pc", ret_pc[4], 32'h40);

    // Misaligned redirect target.
    do_reset();
    wait_ret(1, 20, "t5a");
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    check("t5_trap_before", {31'h0, misalign_trap}, 32'h0);
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t5_trap_pulse", {31'h0, misalign_trap}, {31'h0, TRAP_EN});
    cyc(1);
    @(negedge clk);
    check("t5_trap_after", {31'h0, misalign_trap}, 32'h0);
    wait_req(3, 20, "t5");
    check("t5_req_target", req_log[2], 32'h100);
    wait_ret(2, 20, "t5b");
    check("t5_retired_pc", ret_pc[1], 32'h100);

    // Reset while waiting on a fetch at pc 0x80.
    lat = 3;
    do_reset();
    cyc(1);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    cyc(1);
    redirect_valid = 1'b0;
    wait_req(2, 30, "t6a");
    check("t6_req_0x80", req_log[1], 32'h80);
    reset_n = 1'b0;
    cyc(1);
    @(negedge clk);
    check("t6_rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("t6_rst_addr", imem_req_addr, 32'h0);
    check("t6_rst_inst_pc", inst_pc, 32'h0);
    cyc(1);
    req_log.delete(); ret_pc.delete(); ret_p4.delete();
    lat = 0;
    reset_n = 1'b1;
    wait_req(1, 10, "t6b");
    check("t6_req_after_reset", req_log[0], 32'h0);
    wait_ret(1, 20, "t6c");
    check("t6_pc_after_reset", ret_pc[0], 32'h0);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Sequential instruction-fetch front end that owns the architectural PC register and consumes the next-PC value produced by the PC selection mux. It issues one instruction-memory read at a time over a valid/ready request channel and accepts the reply on a response channel. It presents the fetched instruction with its PC to decode over a valid/ready handshake. It also exports PC+4 back to the mux and absorbs redirects from taken branches and jalr, including discarding in-flight stale responses.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned redirect (used only with FETCH_MISALIGN_TRAP_EN).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- redirect_valid  in  1  taken branch/jal/jalr this cycle.
- redirect_pc  in  32  target from the PC mux (PCNext).
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word address (bits [1:0] always 00).
- imem_rsp_valid  in  1  read data valid, one cycle pulse per accepted request.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst_data  out  32  instruction word.
- inst_pc  out  32  PC of inst_data.
- pc_plus4  out  32  inst_pc + 4, to the PC mux PCPlus4 input.
- misalign_trap  out  1  one-cycle pulse (tied 0 without FETCH_MISALIGN_TRAP_EN).

## Operation
- States: S_REQ (request pending), S_WAIT (awaiting response), S_HOLD (instruction presented), S_DROP (awaiting stale response to discard).
- S_REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, go to S_WAIT.
- S_WAIT: on imem_rsp_valid, capture inst_data and inst_pc=pc, then go to S_HOLD.
- S_HOLD: inst_valid=1. On inst_ready, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), then go to S_REQ.
- Redirect is accepted in any state and has priority over inst_ready and imem_rsp_valid in the same cycle. It loads pc<=redirect_pc & 32'hFFFF_FFFC and drops inst_valid the next cycle.
  - From S_REQ with imem_req_ready high, or from S_WAIT without imem_rsp_valid: go to S_DROP.
  - Otherwise: go to S_REQ.
- S_DROP: on imem_rsp_valid, discard the data and go to S_REQ. A further redirect in S_DROP only updates pc.
- imem_req_valid, once asserted, is held with a stable address until ready, unless a redirect occurs (the address then changes next cycle).
- At most one outstanding request. Responses arriving in S_REQ or S_HOLD are a protocol violation, and the verifier flags them.

## Timing
- Reset (reset_n low at an edge): state=S_REQ, pc=RESET_PC. All outputs are 0 while reset_n is low: imem_req_valid, inst_valid, misalign_trap, inst_data, inst_pc, pc_plus4, and imem_req_addr.
- First request: the cycle after the first edge with reset_n high.
- Reset mid-transaction abandons the outstanding request. The instruction memory is reset by the same reset_n, so no stale response follows.
- Latency from request accept to inst_valid: the memory response cycle plus 1. Minimum 3 cycles per instruction with zero-wait memory.
- inst_data, inst_pc, and pc_plus4 are registered and stable while inst_valid=1 and no redirect occurs.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1]=1 loads pc<=TRAP_VEC instead of the target and pulses misalign_trap for the cycle after the redirect. The state transitions are the same as for a normal redirect.
- Undefined: redirect_pc[1:0] is silently cleared, and misalign_trap is constant 0.

## Structure
- Shared package fetch_pkg: state enum (S_REQ, S_WAIT, S_HOLD, S_DROP), RESET_PC and TRAP_VEC defaults, and a NOP constant 32'h0000_0013 for bench use.
- One sub-module, pc_reg: 32-bit PC with synchronous active-low reset to RESET_PC, load (redirect), and increment-by-4 enables, with load taking priority.

## Test plan
- Reset release with zero-wait memory and inst_ready=1 → addresses 0x0, 0x4, 0x8 requested; inst_pc 0x0, 0x4, 0x8 with pc_plus4 0x4, 0x8, 0xC.
- imem_req_ready low for 4 cycles → imem_req_addr held at 0x0 with imem_req_valid=1; inst_valid only after the grant and response.
- Redirect to 0x200 while in S_WAIT, then response 0xDEADBEEF → word discarded; next request 0x200; inst_pc=0x200.
- Redirect to 0x40 in the same cycle as inst_ready in S_HOLD at pc 0x10 → next request 0x40, not 0x14.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x102 → misalign_trap pulses 1 cycle; next request 0x100 (TRAP_VEC). Without the macro → next request 0x100, trap stays 0.
- reset_n low during S_WAIT at pc 0x80 → outputs 0 next cycle; after release, request 0x0.
